i2c_arbiter: RTL and testbench

Round-robin scheduler that shares a single I2C master engine among `NREQ` requesters. Each requester posts a complete register transaction (7-bit slave address, R/W, register pointer, write byte). The arbiter grants one requester and loads its fields into the master. It then pulses start, waits for completion or timeout, and returns status and read data to the winning requester. It sits between the client blocks and the I2C master, which drives `sda`/`scl`.

---
 rtl/i2c_arbiter.sv | 168 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin scheduler sharing one I2C master among NREQ requesters; grant, m_* and m_start register one edge after req.
// Requesters hold req until their done/err pulse; completion is registered one edge after m_done or at the timeout edge.
module i2c_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_reg,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        rdata,
  output logic              m_start,
  output logic              m_abort,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_reg,
  output logic [7:0]        m_wdata,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rdata
);

  localparam int PW = $clog2(NREQ);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef logic [PW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  idx_t            ptr_q, ptr_d;
  idx_t            idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            m_start_q, m_start_d;
  logic            m_abort_q, m_abort_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic            m_rw_q, m_rw_d;
  logic [7:0]      m_reg_q, m_reg_d;
  logic [7:0]      m_wdata_q, m_wdata_d;

  logic found;
  idx_t win;
  idx_t nxt_ptr;

  // First pending requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign nxt_ptr = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + idx_t'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    m_start_d = 1'b0;
    m_abort_d = 1'b0;
    m_addr_d  = m_addr_q;
    m_rw_d    = m_rw_q;
    m_reg_d   = m_reg_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d     = win;
          gnt_d     = NREQ'(1) << win;
          m_addr_d  = req_addr[7*int'(win) +: 7];
          m_rw_d    = req_rw[win];
          m_reg_d   = req_reg[8*int'(win) +: 8];
          m_wdata_d = req_wdata[8*int'(win) +: 8];
          m_start_d = 1'b1;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A completion landing on the timeout edge takes priority over the abort.
        if (m_done) begin
          if (m_nack) begin
            err_d = gnt_q;
          end else begin
            done_d = gnt_q;
            if (m_rw_q) rdata_d = m_rdata;
          end
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end else if (cnt_q + 16'd1 == TMO) begin
          err_d     = gnt_q;
          m_abort_d = 1'b1;
          gnt_d     = '0;
          ptr_d     = nxt_ptr;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      m_addr_q  <= '0;
      m_rw_q    <= 1'b0;
      m_reg_q   <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      m_start_q <= m_start_d;
      m_abort_q <= m_abort_d;
      m_addr_q  <= m_addr_d;
      m_rw_q    <= m_rw_d;
      m_reg_q   <= m_reg_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign m_start = m_start_q;
  assign m_abort = m_abort_q;
  assign m_addr  = m_addr_q;
  assign m_rw    = m_rw_q;
  assign m_reg   = m_reg_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: directed transactions push expected start/completion events; a negedge monitor pops and checks them.
module tb_i2c_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] req_addr = '0;
  logic [3:0]  req_rw = '0;
  logic [31:0] req_reg = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  gnt, done, err;
  logic [7:0]  rdata;
  logic        m_start, m_abort;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [7:0]  m_reg, m_wdata;
  logic        m_done = 1'b0;
  logic        m_nack = 1'b0;
  logic [7:0]  m_rdata = '0;

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_reg(req_reg), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .m_start(m_start), .m_abort(m_abort), .m_addr(m_addr), .m_rw(m_rw),
    .m_reg(m_reg), .m_wdata(m_wdata), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_end;
    logic [3:0] vec;
    logic [3:0] er;
    logic       ab;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] rd;
    int         dly;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push_start(input logic [3:0] g, input logic [6:0] a, input logic r,
                            input logic [7:0] rg, input logic [7:0] wd, input int dly);
    exp_t e;
    e.is_end = 1'b0; e.vec = g; e.er = '0; e.ab = 1'b0; e.addr = a; e.rw = r;
    e.rg = rg; e.wd = wd; e.rd = '0; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic push_end(input logic [3:0] d, input logic [3:0] er, input logic ab,
                          input logic [7:0] rd, input int dly);
    exp_t e;
    e.is_end = 1'b1; e.vec = d; e.er = er; e.ab = ab; e.addr = '0; e.rw = 1'b0;
    e.rg = '0; e.wd = '0; e.rd = rd; e.dly = dly;
    exp_q.push_back(e);
  endtask

  // Monitor: every negedge, a start or completion pulse consumes one expected event.
  int         cyc = 0;
  int         last_cyc = 0;
  bit         in_txn = 1'b0;
  logic [3:0] cur_gnt = '0;
  exp_t       ev;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_txn = 1'b0;
    end else if (m_start || (|done) || (|err) || m_abort) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got start=%0b done=%b err=%b abort=%0b expected none at %0t",
                 m_start, done, err, m_abort, $time);
      end else begin
        ev = exp_q.pop_front();
        if (ev.dly >= 0) chk("event_delay", 32'(cyc - last_cyc), 32'(ev.dly));
        if (!ev.is_end) begin
          chk("start_seen", 32'(m_start), 32'd1);
          chk("gnt", 32'(gnt), 32'(ev.vec));
          chk("m_addr", 32'(m_addr), 32'(ev.addr));
          chk("m_rw", 32'(m_rw), 32'(ev.rw));
          chk("m_reg", 32'(m_reg), 32'(ev.rg));
          chk("m_wdata", 32'(m_wdata), 32'(ev.wd));
          in_txn  = 1'b1;
          cur_gnt = gnt;
        end else begin
          chk("done", 32'(done), 32'(ev.vec));
          chk("err", 32'(err), 32'(ev.er));
          chk("m_abort", 32'(m_abort), 32'(ev.ab));
          chk("gnt_cleared", 32'(gnt), 32'd0);
          chk("rdata", 32'(rdata), 32'(ev.rd));
          in_txn = 1'b0;
        end
      end
      last_cyc = cyc;
    end else if (in_txn) begin
      chk("gnt_hold", 32'(gnt), 32'(cur_gnt));
    end
  end

  task automatic set_fields(input int i, input logic [6:0] a, input logic r,
                            input logic [7:0] rg, input logic [7:0] wd);
    req_addr[7*i +: 7]  = a;
    req_rw[i]           = r;
    req_reg[8*i +: 8]   = rg;
    req_wdata[8*i +: 8] = wd;
  endtask

  task automatic wait_start();
    int t = 0;
    while (!m_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!m_start) begin
      n_bad++;
      $display("FAIL wait_start: got no m_start expected one within 100 cycles at %0t", $time);
    end
  endtask

  task automatic wait_end();
    int t = 0;
    while (!((|done) || (|err)) && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!((|done) || (|err))) begin
      n_bad++;
      $display("FAIL wait_end: got no done/err expected one within 100 cycles at %0t", $time);
    end
  endtask

  // Master model: m_done is driven L negedges after m_start is seen, so it is sampled L+1 edges after the grant.
  task automatic run_txn(input int l, input logic nack, input logic [7:0] rd);
    wait_start();
    repeat (l) @(negedge clk);
    m_done = 1'b1; m_nack = nack; m_rdata = rd;
    @(negedge clk);
    m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_m_start"}, 32'(m_start), 32'd0);
    chk({tag, "_m_abort"}, 32'(m_abort), 32'd0);
    chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_m_rw"}, 32'(m_rw), 32'd0);
    chk({tag, "_m_reg"}, 32'(m_reg), 32'd0);
    chk({tag, "_m_wdata"}, 32'(m_wdata), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected one before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int w;

    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write from requester 1.
    set_fields(1, 7'h69, 1'b0, 8'h25, 8'hA5);
    push_start(4'b0010, 7'h69, 1'b0, 8'h25, 8'hA5, -1);
    push_end(4'b0010, 4'b0000, 1'b0, 8'h00, 8);
    req = 4'b0010;
    run_txn(7, 1'b0, 8'h00);
    req = '0;

    // Read from requester 2 loads rdata.
    set_fields(2, 7'h50, 1'b1, 8'h25, 8'h33);
    push_start(4'b0100, 7'h50, 1'b1, 8'h25, 8'h33, -1);
    push_end(4'b0100, 4'b0000, 1'b0, 8'h10, 4);
    req = 4'b0100;
    run_txn(3, 1'b0, 8'h10);
    req = '0;

    // Write with stray m_rdata must not disturb rdata.
    set_fields(3, 7'h11, 1'b0, 8'h02, 8'h5A);
    push_start(4'b1000, 7'h11, 1'b0, 8'h02, 8'h5A, -1);
    push_end(4'b1000, 4'b0000, 1'b0, 8'h10, 3);
    req = 4'b1000;
    run_txn(2, 1'b0, 8'hEE);
    req = '0;

    // Fairness: all four held, pointer at 0.
    for (int i = 0; i < 4; i++)
      set_fields(i, 7'(64 + i), 1'b0, 8'(16 + i), 8'(192 + i));
    for (int k = 0; k < 5; k++) begin
      w = order[k];
      push_start(4'(1 << w), 7'(64 + w), 1'b0, 8'(16 + w), 8'(192 + w), (k == 0) ? -1 : 1);
      push_end(4'(1 << w), 4'b0000, 1'b0, 8'h10, 5);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) run_txn(4, 1'b0, 8'h00);
    req = '0;

    // NACK on a read: err only, rdata unchanged.
    set_fields(1, 7'h22, 1'b1, 8'h07, 8'h00);
    push_start(4'b0010, 7'h22, 1'b1, 8'h07, 8'h00, -1);
    push_end(4'b0000, 4'b0010, 1'b0, 8'h10, 5);
    req = 4'b0010;
    run_txn(4, 1'b1, 8'h99);
    req = '0;

    // m_done on the timeout edge: done wins, no abort.
    set_fields(2, 7'h33, 1'b0, 8'h44, 8'h55);
    push_start(4'b0100, 7'h33, 1'b0, 8'h44, 8'h55, -1);
    push_end(4'b0100, 4'b0000, 1'b0, 8'h10, TO + 1);
    req = 4'b0100;
    run_txn(TO, 1'b0, 8'h00);
    req = '0;

    // Timeout: m_done in ISSUE is ignored, abort fires TO cycles into WAIT, late m_done ignored.
    set_fields(3, 7'h0F, 1'b1, 8'hF0, 8'h00);
    push_start(4'b1000, 7'h0F, 1'b1, 8'hF0, 8'h00, -1);
    push_end(4'b0000, 4'b1000, 1'b1, 8'h10, TO + 1);
    req = 4'b1000;
    wait_start();
    m_done = 1'b1; m_rdata = 8'h77;
    @(negedge clk);
    m_done = 1'b0; m_rdata = '0;
    wait_end();
    req = '0;
    repeat (2) @(negedge clk);
    m_done = 1'b1; m_rdata = 8'h66;
    @(negedge clk);
    m_done = 1'b0; m_rdata = '0;
    repeat (3) @(negedge clk);

    // Reset in the middle of WAIT.
    set_fields(1, 7'h2A, 1'b0, 8'h01, 8'h02);
    push_start(4'b0010, 7'h2A, 1'b0, 8'h01, 8'h02, -1);
    req = 4'b0010;
    wait_start();
    repeat (3) @(negedge clk);
    chk("gnt_before_rst", 32'(gnt), 32'b0010);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Pointer back at 0 after reset.
    set_fields(0, 7'h01, 1'b0, 8'hA0, 8'hB0);
    set_fields(3, 7'h03, 1'b0, 8'hA3, 8'hB3);
    push_start(4'b0001, 7'h01, 1'b0, 8'hA0, 8'hB0, -1);
    push_end(4'b0001, 4'b0000, 1'b0, 8'h00, 2);
    push_start(4'b1000, 7'h03, 1'b0, 8'hA3, 8'hB3, 1);
    push_end(4'b1000, 4'b0000, 1'b0, 8'h00, 2);
    push_start(4'b0001, 7'h01, 1'b0, 8'hA0, 8'hB0, 1);
    push_end(4'b0001, 4'b0000, 1'b0, 8'h00, 2);
    req = 4'b1001;
    run_txn(1, 1'b0, 8'h00);
    req = 4'b1000;
    run_txn(1, 1'b0, 8'h00);
    req = 4'b1001;
    run_txn(1, 1'b0, 8'h00);
    req = '0;

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
